ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits between the ID/EX register and the memory stage.
- Computes the ALU result with EX/MEM and MEM/WB forwarding.
- Runs a 32-cycle iterative unsigned multiplier (multu/mfhi/mflo) that raises a stall while busy.
- Registers address, store data, destination and control into the EX/MEM register, which drives the memory stage directly.

Parameters:
- W, 32, datapath width.
- MUL_CYCLES, 32, iterations of the shift-add multiplier; equals W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID/EX holds a real instruction.
- read_data1, read_data2  in  32  rs/rt register values from ID/EX.
- sign_ext_imm  in  32  sign-extended immediate.
- rs, rt, rd  in  5  register specifiers.
- alu_op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 1100 NOR; others give 0.
- alusrc  in  1  1 selects sign_ext_imm as ALU operand B.
- regdst  in  1  1 selects rd as destination, 0 selects rt.
- memread, memwrite, memtoreg, regwrite  in  1  control bits carried to MEM.
- mul_start, mfhi, mflo  in  1  multu / move-from-HI / move-from-LO decode.
- wb_rd  in  5  MEM/WB destination register.
- wb_regwrite  in  1  MEM/WB write enable.
- wb_data  in  32  MEM/WB writeback value.
- EX_M_address  out  32  registered ALU result.
- EX_M_write_data  out  32  registered forwarded rt value.
- EX_M_rd  out  5  registered destination.
- EX_M_memread, EX_M_memwrite, EX_M_memtoreg, EX_M_regwrite  out  1  registered control.
- stall  out  1  combinational; hold PC/IF/ID/ID-EX this cycle.

Behaviour:
- Reset: async on rst high.
  - All EX_M_* outputs go to 0.
  - HI and LO go to 0; multiplier state goes to IDLE, counter to 0.
  - stall goes to 0.
  - Reset mid-multiply aborts the operation; no partial HI/LO survives.
- Forwarding, per operand A (rs) and B (rt):
  - Forward EX_M_address if EX_M_regwrite and EX_M_rd equals the source and EX_M_rd is not 0. This path has priority.
  - Else forward wb_data if wb_regwrite and wb_rd equals the source and wb_rd is not 0.
  - Else use the register value.
  - Load-use hazards are the hazard unit's job; this block does not detect them.
- Operand B: sign_ext_imm if alusrc, else forwarded rt. EX_M_write_data is always forwarded rt.
- ALU: W-bit wrap-around add/sub, no overflow trap. SLT compares signed and yields 1 or 0.
- Result mux: mfhi gives HI, mflo gives LO, otherwise ALU output.
- Destination: regdst ? rd : rt.
- Multiplier FSM, IDLE and BUSY:
  - IDLE to BUSY when id_valid & mul_start. Latch forwarded A and B, clear the product accumulator, counter = 0.
  - In BUSY, one shift-add step per cycle.
  - After MUL_CYCLES steps, write the 64-bit product: HI = upper W bits, LO = lower W bits. Return to IDLE.
  - multu issued in cycle N: HI/LO valid from cycle N+MUL_CYCLES+1. An mfhi issued in that cycle reads the new value.
- stall = BUSY & id_valid & (mul_start | mfhi | mflo). Other instructions proceed while BUSY.
- EX/MEM register, on every rising edge unless rst:
  - If stall, or !id_valid, or mul_start: load a bubble. All four control outputs = 0; data fields = 0.
  - Otherwise load the computed values.
- Latency: one cycle from ID/EX inputs to EX_M_* outputs.

Test Plan:
- ADD with no hazards: A=5, B=7, alu_op=0010, regdst=1, rd=3 -> next cycle EX_M_address=12, EX_M_rd=3, EX_M_regwrite=1.
- Forward priority: EX_M_rd=8 holding 100 and wb_rd=8 with wb_data=200; SUB with rs=8 and read_data2=1 -> 99. Repeat with EX_M_rd=0 -> 199.
- SLT signed: A=0xFFFFFFFF, B=1 -> 1. NOR of 0 and 0 -> 0xFFFFFFFF.
- multu 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE. mflo issued at cycle N+5 -> stall=1 until N+32; mflo at N+33 returns 0xFFFFFFFE.
- ADD issued during BUSY -> stall=0 and correct result. multu itself leaves EX_M_regwrite=0.
- rst pulsed mid-multiply at step 10 -> HI=LO=0, stall=0 immediately, EX_M_* = 0. A subsequent mfhi returns 0.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
// The execute stage connects through the slave modport; the driver of the pipeline connects through master.
interface ex_stage_if #(
    parameter int W = 32
);
    logic         id_valid;
    logic [W-1:0] read_data1;
    logic [W-1:0] read_data2;
    logic [W-1:0] sign_ext_imm;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [3:0]   alu_op;
    logic         alusrc;
    logic         regdst;
    logic         memread;
    logic         memwrite;
    logic         memtoreg;
    logic         regwrite;
    logic         mul_start;
    logic         mfhi;
    logic         mflo;
    logic [4:0]   wb_rd;
    logic         wb_regwrite;
    logic [W-1:0] wb_data;

    logic [W-1:0] EX_M_address;
    logic [W-1:0] EX_M_write_data;
    logic [4:0]   EX_M_rd;
    logic         EX_M_memread;
    logic         EX_M_memwrite;
    logic         EX_M_memtoreg;
    logic         EX_M_regwrite;
    logic         stall;
    logic         dbg_mul_state;

    // Pipeline contract: EX_M_* move on every rising edge. When stall is high, the
    // upstream stages hold their contents and the EX/MEM register loads a bubble.
    modport master (
        output id_valid, read_data1, read_data2, sign_ext_imm, rs, rt, rd, alu_op,
               alusrc, regdst, memread, memwrite, memtoreg, regwrite, mul_start,
               mfhi, mflo, wb_rd, wb_regwrite, wb_data,
        input  EX_M_address, EX_M_write_data, EX_M_rd, EX_M_memread, EX_M_memwrite,
               EX_M_memtoreg, EX_M_regwrite, stall, dbg_mul_state
    );

    modport slave (
        input  id_valid, read_data1, read_data2, sign_ext_imm, rs, rt, rd, alu_op,
               alusrc, regdst, memread, memwrite, memtoreg, regwrite, mul_start,
               mfhi, mflo, wb_rd, wb_regwrite, wb_data,
        output EX_M_address, EX_M_write_data, EX_M_rd, EX_M_memread, EX_M_memwrite,
               EX_M_memtoreg, EX_M_regwrite, stall, dbg_mul_state
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding ALU, iterative multu with HI/LO, and the EX/MEM register.
// dbg_mul_state exposes the multiplier FSM state (0 idle, 1 busy).
module ex_stage #(
    parameter int W          = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  ex_bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam int         CW     = $clog2(MUL_CYCLES) + 1;

    logic [0:0]     r_state;
    logic [CW-1:0]  r_count;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic [W-1:0]   r_address;
    logic [W-1:0]   r_write_data;
    logic [4:0]     r_rd;
    logic           r_memread;
    logic           r_memwrite;
    logic           r_memtoreg;
    logic           r_regwrite;

    logic [W-1:0]   w_fwd_a;
    logic [W-1:0]   w_fwd_b;
    logic [W-1:0]   w_op_b;
    logic [W-1:0]   w_alu;
    logic [W-1:0]   w_result;
    logic [4:0]     w_dest;
    logic [2*W-1:0] w_acc_next;
    logic           w_stall;
    logic           w_bubble;
    logic           w_slt;

    // EX/MEM forwarding wins over MEM/WB; register 0 is never forwarded.
    always_comb begin
        w_fwd_a = ex_bus.read_data1;
        if (r_regwrite && (r_rd != 5'd0) && (r_rd == ex_bus.rs))
            w_fwd_a = r_address;
        else if (ex_bus.wb_regwrite && (ex_bus.wb_rd != 5'd0) && (ex_bus.wb_rd == ex_bus.rs))
            w_fwd_a = ex_bus.wb_data;

        w_fwd_b = ex_bus.read_data2;
        if (r_regwrite && (r_rd != 5'd0) && (r_rd == ex_bus.rt))
            w_fwd_b = r_address;
        else if (ex_bus.wb_regwrite && (ex_bus.wb_rd != 5'd0) && (ex_bus.wb_rd == ex_bus.rt))
            w_fwd_b = ex_bus.wb_data;
    end

    assign w_op_b = ex_bus.alusrc ? ex_bus.sign_ext_imm : w_fwd_b;
    assign w_slt  = $signed(w_fwd_a) < $signed(w_op_b);

    always_comb begin
        w_alu = '0;
        case (ex_bus.alu_op)
            4'b0000: w_alu = w_fwd_a & w_op_b;
            4'b0001: w_alu = w_fwd_a | w_op_b;
            4'b0010: w_alu = w_fwd_a + w_op_b;
            4'b0110: w_alu = w_fwd_a - w_op_b;
            4'b0111: w_alu = {{(W-1){1'b0}}, w_slt};
            4'b1100: w_alu = ~(w_fwd_a | w_op_b);
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_result = w_alu;
        if (ex_bus.mfhi)
            w_result = r_hi;
        else if (ex_bus.mflo)
            w_result = r_lo;
    end

    assign w_dest     = ex_bus.regdst ? ex_bus.rd : ex_bus.rt;
    assign w_stall    = (r_state == S_BUSY) && ex_bus.id_valid &&
                        (ex_bus.mul_start || ex_bus.mfhi || ex_bus.mflo);
    assign w_bubble   = w_stall || !ex_bus.id_valid || ex_bus.mul_start;
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Shift-add: multiplicand walks left, multiplier walks right, one bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (r_state == S_IDLE) begin
            if (ex_bus.id_valid && ex_bus.mul_start) begin
                r_mcand  <= {{W{1'b0}}, w_fwd_a};
                r_mplier <= w_fwd_b;
                r_acc    <= '0;
                r_count  <= '0;
                r_state  <= S_BUSY;
            end
        end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (r_count == CW'(MUL_CYCLES - 1)) begin
                r_hi    <= w_acc_next[2*W-1:W];
                r_lo    <= w_acc_next[W-1:0];
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_address    <= '0;
            r_write_data <= '0;
            r_rd         <= '0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
        end else if (w_bubble) begin
            r_address    <= '0;
            r_write_data <= '0;
            r_rd         <= '0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
        end else begin
            r_address    <= w_result;
            r_write_data <= w_fwd_b;
            r_rd         <= w_dest;
            r_memread    <= ex_bus.memread;
            r_memwrite   <= ex_bus.memwrite;
            r_memtoreg   <= ex_bus.memtoreg;
            r_regwrite   <= ex_bus.regwrite;
        end
    end

    assign ex_bus.EX_M_address    = r_address;
    assign ex_bus.EX_M_write_data = r_write_data;
    assign ex_bus.EX_M_rd         = r_rd;
    assign ex_bus.EX_M_memread    = r_memread;
    assign ex_bus.EX_M_memwrite   = r_memwrite;
    assign ex_bus.EX_M_memtoreg   = r_memtoreg;
    assign ex_bus.EX_M_regwrite   = r_regwrite;
    assign ex_bus.stall           = w_stall;
    assign ex_bus.dbg_mul_state   = r_state[0];
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, EX/MEM bubbles, multu timing and reset abort.
module tb_ex_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    ex_stage_if #(.W(W)) bus ();

    ex_stage #(.W(W), .MUL_CYCLES(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .ex_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [8];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid     = 1'b0;
        bus.read_data1   = '0;
        bus.read_data2   = '0;
        bus.sign_ext_imm = '0;
        bus.rs           = '0;
        bus.rt           = '0;
        bus.rd           = '0;
        bus.alu_op       = '0;
        bus.alusrc       = 1'b0;
        bus.regdst       = 1'b0;
        bus.memread      = 1'b0;
        bus.memwrite     = 1'b0;
        bus.memtoreg     = 1'b0;
        bus.regwrite     = 1'b0;
        bus.mul_start    = 1'b0;
        bus.mfhi         = 1'b0;
        bus.mflo         = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_regwrite  = 1'b0;
        bus.wb_data      = '0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [4:0] rs_i, input logic [4:0] rt_i,
                             input logic [4:0] rd_i, input logic [W-1:0] a, input logic [W-1:0] b);
        clear_inputs();
        bus.id_valid   = 1'b1;
        bus.regwrite   = 1'b1;
        bus.regdst     = 1'b1;
        bus.alu_op     = op;
        bus.rs         = rs_i;
        bus.rt         = rt_i;
        bus.rd         = rd_i;
        bus.read_data1 = a;
        bus.read_data2 = b;
    endtask

    task automatic drive_multu(input logic [W-1:0] a, input logic [W-1:0] b);
        clear_inputs();
        bus.id_valid   = 1'b1;
        bus.mul_start  = 1'b1;
        bus.rs         = 5'd1;
        bus.rt         = 5'd2;
        bus.read_data1 = a;
        bus.read_data2 = b;
    endtask

    task automatic check_ex(input string tag, input logic [W-1:0] addr, input logic [4:0] rd_e,
                            input logic regwrite_e);
        check({tag, "_addr"}, bus.EX_M_address, addr);
        check({tag, "_rd"}, W'(bus.EX_M_rd), W'(rd_e));
        check({tag, "_regwrite"}, W'(bus.EX_M_regwrite), W'(regwrite_e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[1] = '{4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0};
        vecs[2] = '{4'b1100, 32'd0,         32'd0,         32'hFFFF_FFFF};
        vecs[3] = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[4] = '{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[5] = '{4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF};
        vecs[6] = '{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[7] = '{4'b0011, 32'd5,         32'd7,         32'd0};

        // reset
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_ex("reset", '0, 5'd0, 1'b0);
        check("reset_wdata", bus.EX_M_write_data, '0);
        check("reset_stall", W'(bus.stall), '0);
        check("reset_state", W'(bus.dbg_mul_state), '0);
        rst = 1'b0;

        // plain ADD
        drive_alu(4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        check_ex("add", 32'd12, 5'd3, 1'b1);
        check("add_wdata", bus.EX_M_write_data, 32'd7);

        // EX/MEM beats MEM/WB
        drive_alu(4'b0010, 5'd1, 5'd2, 5'd8, 32'd100, 32'd0);
        tick();
        check_ex("seed_r8", 32'd100, 5'd8, 1'b1);
        drive_alu(4'b0110, 5'd8, 5'd9, 5'd10, 32'd55, 32'd1);
        bus.wb_rd = 5'd8; bus.wb_regwrite = 1'b1; bus.wb_data = 32'd200;
        tick();
        check_ex("fwd_ex", 32'd99, 5'd10, 1'b1);

        // EX/MEM targets r0, so MEM/WB supplies rs
        drive_alu(4'b0010, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0);
        tick();
        check_ex("seed_r0", 32'd100, 5'd0, 1'b1);
        drive_alu(4'b0110, 5'd8, 5'd9, 5'd0, 32'd55, 32'd1);
        bus.wb_rd = 5'd8; bus.wb_regwrite = 1'b1; bus.wb_data = 32'd200;
        tick();
        check_ex("fwd_wb", 32'd199, 5'd0, 1'b1);

        // reading r0 is never forwarded from either stage
        drive_alu(4'b0110, 5'd0, 5'd9, 5'd26, 32'd0, 32'd1);
        bus.wb_rd = 5'd0; bus.wb_regwrite = 1'b1; bus.wb_data = 32'd200;
        tick();
        check_ex("fwd_r0", 32'hFFFF_FFFF, 5'd26, 1'b1);

        // operand B from MEM/WB, then from EX/MEM
        drive_alu(4'b0001, 5'd1, 5'd8, 5'd27, 32'h0F0, 32'd0);
        bus.wb_rd = 5'd8; bus.wb_regwrite = 1'b1; bus.wb_data = 32'h00F;
        tick();
        check_ex("fwd_b_wb", 32'h0FF, 5'd27, 1'b1);
        check("fwd_b_wb_wdata", bus.EX_M_write_data, 32'h00F);
        drive_alu(4'b0000, 5'd1, 5'd27, 5'd28, 32'hFFFF_FFFF, 32'd0);
        tick();
        check_ex("fwd_b_ex", 32'h0FF, 5'd28, 1'b1);
        check("fwd_b_ex_wdata", bus.EX_M_write_data, 32'h0FF);

        // immediate operand, rt destination, memory control bits
        drive_alu(4'b0010, 5'd1, 5'd21, 5'd29, 32'd10, 32'd999);
        bus.alusrc = 1'b1; bus.sign_ext_imm = 32'hFFFF_FFFE; bus.regdst = 1'b0;
        bus.memread = 1'b1; bus.memtoreg = 1'b1;
        tick();
        check_ex("imm", 32'd8, 5'd21, 1'b1);
        check("imm_wdata", bus.EX_M_write_data, 32'd999);
        check("imm_memread", W'(bus.EX_M_memread), 32'd1);
        check("imm_memtoreg", W'(bus.EX_M_memtoreg), 32'd1);
        check("imm_memwrite", W'(bus.EX_M_memwrite), 32'd0);

        // invalid slot becomes a bubble
        drive_alu(4'b0010, 5'd1, 5'd2, 5'd30, 32'd5, 32'd7);
        bus.memwrite = 1'b1;
        bus.id_valid = 1'b0;
        tick();
        check_ex("bubble", '0, 5'd0, 1'b0);
        check("bubble_memwrite", W'(bus.EX_M_memwrite), 32'd0);

        // ALU table
        for (int i = 0; i < 8; i++) begin
            drive_alu(vecs[i].op, 5'd1, 5'd2, 5'd24, vecs[i].a, vecs[i].b);
            exp_q.push_back(vecs[i].exp);
            tick();
            check($sformatf("alu%0d", i), bus.EX_M_address, exp_q.pop_front());
        end

        // multu 0xFFFFFFFF x 2 issued in cycle N
        drive_multu(32'hFFFF_FFFF, 32'd2);
        #1;
        check("multu_issue_stall", W'(bus.stall), '0);
        tick();
        check("multu_bubble_regwrite", W'(bus.EX_M_regwrite), '0);
        check("multu_busy", W'(bus.dbg_mul_state), 32'd1);
        // N+1: independent ADD proceeds while busy
        drive_alu(4'b0010, 5'd1, 5'd2, 5'd22, 32'd3, 32'd4);
        #1;
        check("busy_add_stall", W'(bus.stall), '0);
        tick();
        check_ex("busy_add", 32'd7, 5'd22, 1'b1);
        clear_inputs();
        tick();
        tick();
        tick();
        // N+5 .. N+32: mflo held under stall
        clear_inputs();
        bus.id_valid = 1'b1; bus.mflo = 1'b1; bus.regdst = 1'b1; bus.rd = 5'd23; bus.regwrite = 1'b1;
        for (int c = 5; c <= 32; c++) begin
            #1;
            check($sformatf("mflo_stall_c%0d", c), W'(bus.stall), 32'd1);
            check($sformatf("mflo_stall_bubble_c%0d", c), W'(bus.EX_M_regwrite), '0);
            tick();
        end
        // N+33: product available
        #1;
        check("mflo_release", W'(bus.stall), '0);
        check("mul_idle", W'(bus.dbg_mul_state), '0);
        tick();
        check_ex("mflo", 32'hFFFF_FFFE, 5'd23, 1'b1);
        bus.mflo = 1'b0; bus.mfhi = 1'b1; bus.rd = 5'd25;
        tick();
        check_ex("mfhi", 32'd1, 5'd25, 1'b1);

        // reset after 10 multiplier steps
        drive_multu(32'd5, 32'd7);
        tick();
        clear_inputs();
        for (int s = 0; s < 9; s++) tick();
        drive_alu(4'b0010, 5'd1, 5'd2, 5'd22, 32'd3, 32'd4);
        tick();
        check_ex("pre_rst_add", 32'd7, 5'd22, 1'b1);
        clear_inputs();
        bus.id_valid = 1'b1; bus.mfhi = 1'b1; bus.regdst = 1'b1; bus.rd = 5'd25; bus.regwrite = 1'b1;
        #1;
        check("pre_rst_stall", W'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_stall", W'(bus.stall), '0);
        check("rst_state", W'(bus.dbg_mul_state), '0);
        check_ex("rst_ex", '0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_stall", W'(bus.stall), '0);
        tick();
        check_ex("post_rst_mfhi", '0, 5'd25, 1'b1);
        bus.mfhi = 1'b0; bus.mflo = 1'b1; bus.rd = 5'd23;
        tick();
        check_ex("post_rst_mflo", '0, 5'd23, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
